// File: rtl/keypad_pkg.sv
// Shared 4x4 keypad definitions: key codes and the code -> (row, column) map.
// Pure declarations, no latency; no flow control.
// Scanners, decoders and the emulator all use this map so they agree by construction.
package keypad_pkg;

    localparam logic [3:0] KEY_0 = 4'h0;
    localparam logic [3:0] KEY_1 = 4'h1;
    localparam logic [3:0] KEY_2 = 4'h2;
    localparam logic [3:0] KEY_3 = 4'h3;
    localparam logic [3:0] KEY_4 = 4'h4;
    localparam logic [3:0] KEY_5 = 4'h5;
    localparam logic [3:0] KEY_6 = 4'h6;
    localparam logic [3:0] KEY_7 = 4'h7;
    localparam logic [3:0] KEY_8 = 4'h8;
    localparam logic [3:0] KEY_9 = 4'h9;
    localparam logic [3:0] KEY_A = 4'hA;
    localparam logic [3:0] KEY_B = 4'hB;
    localparam logic [3:0] KEY_C = 4'hC;
    localparam logic [3:0] KEY_D = 4'hD;
    localparam logic [3:0] KEY_E = 4'hE;
    localparam logic [3:0] KEY_F = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_GAP   = 2'd2
    } emu_state_t;

    // Row index 0..3 corresponds to R1..R4.
    function automatic logic [1:0] key_to_row(input logic [3:0] code);
        logic [1:0] r;
        case (code)
            KEY_1, KEY_2, KEY_3, KEY_A: r = 2'd0;
            KEY_4, KEY_5, KEY_6, KEY_B: r = 2'd1;
            KEY_7, KEY_8, KEY_9, KEY_C: r = 2'd2;
            default:                    r = 2'd3;
        endcase
        return r;
    endfunction

    // Column index 0..3 corresponds to C1..C4.
    function automatic logic [1:0] key_to_col(input logic [3:0] code);
        logic [1:0] c;
        case (code)
            KEY_1, KEY_4, KEY_7, KEY_E: c = 2'd0;
            KEY_2, KEY_5, KEY_8, KEY_0: c = 2'd1;
            KEY_3, KEY_6, KEY_9, KEY_F: c = 2'd2;
            default:                    c = 2'd3;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// Key-code stream plus keypad row/column lines between stimulus/scanner and emulator.
// No latency of its own; key_valid/key_ready handshake on the key stream.
// Row/column lines carry no flow control.
interface keypad_emulator_if;
    logic [3:0] key_in;
    logic       key_valid;
    logic       key_ready;
    logic [3:0] row;
    logic [3:0] column;
    logic       pressed;
    logic [3:0] key_active;
    logic       busy;

    modport master (
        output key_in, key_valid, row,
        input  key_ready, column, pressed, key_active, busy
    );

    modport slave (
        input  key_in, key_valid, row,
        output key_ready, column, pressed, key_active, busy
    );
endinterface

// File: rtl/keypad_emu_fifo.sv
// Small synchronous FIFO with show-ahead read data and full/empty flags.
// Write visible at the head one cycle after the push edge.
// Push while full is dropped; pop while empty is ignored.
module keypad_emu_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dat,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer bit separates full from empty when the index bits match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_dat     = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/keypad_emulator.sv
// 4x4 keypad emulator: queues key codes, presses each for HOLD_CYCLES, releases for GAP_CYCLES.
// Pop one edge after a push into an empty idle queue; row->column is purely combinational.
// key_ready drops when the queue is full. Optional contact bounce: KEYPAD_EMU_BOUNCE_EN.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int HOLD_CYCLES = 1000,
    parameter int GAP_CYCLES  = 1000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    keypad_emulator_if.slave  kp
);
    localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_CYC);

    emu_state_t     r_state;
    emu_state_t     w_state_nxt;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_nxt;
    logic [3:0]     r_key_active;
    logic           w_pop;
    logic           w_empty;
    logic           w_full;
    logic [3:0]     w_head;
    logic           w_contact;
    logic           w_row_hit;
    logic [1:0]     w_row_idx;
    logic [1:0]     w_col_idx;
    logic [3:0]     w_column;

    keypad_emu_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (4)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (kp.key_valid),
        .i_dat   (kp.key_in),
        .i_pop   (w_pop),
        .o_dat   (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (!w_empty) begin
                    w_state_nxt = ST_PRESS;
                    w_pop       = 1'b1;
                end
            end
            ST_PRESS: begin
                if (r_cnt == CW'(HOLD_CYCLES - 1)) begin
                    w_state_nxt = ST_GAP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (r_cnt == CW'(GAP_CYCLES - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_key_active <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_pop) r_key_active <= w_head;
        end
    end

`ifdef KEYPAD_EMU_BOUNCE_EN
    // First 8 press cycles chatter closed/open in pairs, then settle closed.
    assign w_contact = (r_state == ST_PRESS) && ((r_cnt >= CW'(8)) || !r_cnt[1]);
`else
    assign w_contact = (r_state == ST_PRESS);
`endif

    assign w_row_idx = key_to_row(r_key_active);
    assign w_col_idx = key_to_col(r_key_active);
    // Only a driven-low row counts as a strobe; undriven or unknown reads as released.
    assign w_row_hit = (kp.row[w_row_idx] === 1'b0);

    always_comb begin
        w_column = 4'b1111;
        if (w_contact && w_row_hit) begin
            w_column[w_col_idx] = 1'b0;
        end
    end

    assign kp.column     = w_column;
    assign kp.pressed    = w_contact;
    assign kp.key_active = r_key_active;
    assign kp.key_ready  = !w_full;
    assign kp.busy       = !w_empty || (r_state != ST_IDLE);
endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator with HOLD_CYCLES=16, GAP_CYCLES=4, FIFO_DEPTH=4.
module tb_keypad_emulator;
    import keypad_pkg::*;

    localparam int HOLD  = 16;
    localparam int GAP   = 4;
    localparam int DEPTH = 4;

    typedef struct {
        logic [3:0] code;
        logic [3:0] row_in;
        logic [3:0] col_exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic [3:0] kmap [16];
    vec_t vecs [19];

    keypad_emulator_if kp_if ();

    keypad_emulator #(
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kp_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Contact state in PRESS cycle i (0-based).
    function automatic logic exp_closed(input int i);
`ifdef KEYPAD_EMU_BOUNCE_EN
        return (i < HOLD) && ((i >= 8) || (((i / 2) % 2) == 0));
`else
        return (i < HOLD);
`endif
    endfunction

    function automatic logic [3:0] decode(input logic [3:0] r, input logic [3:0] c);
        int ri = 0;
        int ci = 0;
        for (int k = 0; k < 4; k++) begin
            if (r[k] == 1'b0) ri = k;
            if (c[k] == 1'b0) ci = k;
        end
        return kmap[ri * 4 + ci];
    endfunction

    task automatic push(input logic [3:0] code);
        check1("key_ready before push", kp_if.key_ready, 1'b1);
        kp_if.key_in    = code;
        kp_if.key_valid = 1'b1;
        @(posedge clk);
        #1 kp_if.key_valid = 1'b0;
    endtask

    // which: 0 = pressed, 1 = busy. Bounded wait; a timeout shows up as a failed check.
    task automatic wait_sig(input string name, input int which, input logic lvl, input int max_cyc);
        logic v = ~lvl;
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clk);
            v = (which == 0) ? kp_if.pressed : kp_if.busy;
            if (v === lvl) break;
        end
        check1(name, v, lvl);
    endtask

    // Full cycle-by-cycle trace of one key from an idle, empty emulator.
    task automatic trace_key(input logic [3:0] code, input logic [3:0] row_in, input logic [3:0] col_exp);
        kp_if.row = row_in;
        push(code);
        @(negedge clk);
        check1("latency pressed low after accept", kp_if.pressed, 1'b0);
        check1("latency busy after accept", kp_if.busy, 1'b1);
        for (int i = 0; i < HOLD; i++) begin
            @(negedge clk);
            check4($sformatf("press column cycle %0d", i), kp_if.column,
                   exp_closed(i) ? col_exp : 4'b1111);
            check1($sformatf("press pressed cycle %0d", i), kp_if.pressed, exp_closed(i));
        end
        for (int i = 0; i < GAP; i++) begin
            @(negedge clk);
            check4($sformatf("gap column cycle %0d", i), kp_if.column, 4'b1111);
            check1($sformatf("gap pressed cycle %0d", i), kp_if.pressed, 1'b0);
            check1($sformatf("gap busy cycle %0d", i), kp_if.busy, 1'b1);
        end
        @(negedge clk);
        check1("busy low after gap", kp_if.busy, 1'b0);
        check4("key_active holds after press", kp_if.key_active, code);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got_n;
        int miss;
        int hi;
        logic [3:0] got [8];
        logic [3:0] code;

        n_checks = 0;
        n_fail   = 0;
        kmap = '{KEY_1, KEY_2, KEY_3, KEY_A,
                 KEY_4, KEY_5, KEY_6, KEY_B,
                 KEY_7, KEY_8, KEY_9, KEY_C,
                 KEY_E, KEY_0, KEY_F, KEY_D};
        vecs = '{
            '{KEY_1, 4'b1110, 4'b1110}, '{KEY_2, 4'b1110, 4'b1101},
            '{KEY_3, 4'b1110, 4'b1011}, '{KEY_A, 4'b1110, 4'b0111},
            '{KEY_4, 4'b1101, 4'b1110}, '{KEY_5, 4'b1101, 4'b1101},
            '{KEY_6, 4'b1101, 4'b1011}, '{KEY_B, 4'b1101, 4'b0111},
            '{KEY_7, 4'b1011, 4'b1110}, '{KEY_8, 4'b1011, 4'b1101},
            '{KEY_9, 4'b1011, 4'b1011}, '{KEY_C, 4'b1011, 4'b0111},
            '{KEY_E, 4'b0111, 4'b1110}, '{KEY_0, 4'b0111, 4'b1101},
            '{KEY_F, 4'b0111, 4'b1011}, '{KEY_D, 4'b0111, 4'b0111},
            '{KEY_E, 4'b0110, 4'b1110}, '{KEY_5, 4'b1011, 4'b1111},
            '{KEY_5, 4'b0000, 4'b1101}
        };

        rst_n           = 1'b0;
        kp_if.key_in    = 4'h0;
        kp_if.key_valid = 1'b0;
        kp_if.row       = 4'b1111;
        repeat (3) @(negedge clk);
        check4("reset column", kp_if.column, 4'b1111);
        check1("reset pressed", kp_if.pressed, 1'b0);
        check4("reset key_active", kp_if.key_active, 4'h0);
        check1("reset busy", kp_if.busy, 1'b0);
        check1("reset key_ready", kp_if.key_ready, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);
        check1("idle busy after reset", kp_if.busy, 1'b0);

        // Key 5 is R2/C2; key 9 is R3/C3 (column[2]).
        trace_key(KEY_5, 4'b1101, 4'b1101);
        trace_key(KEY_9, 4'b1011, 4'b1011);

        for (int i = 0; i < 19; i++) begin
            kp_if.row = 4'b1111;
            push(vecs[i].code);
            wait_sig($sformatf("table %0d pressed", i), 0, 1'b1, 6);
            kp_if.row = vecs[i].row_in;
            #1 check4($sformatf("table %0d column", i), kp_if.column, vecs[i].col_exp);
            check4($sformatf("table %0d key_active", i), kp_if.key_active, vecs[i].code);
            kp_if.row = 4'b1111;
            #1 check4($sformatf("table %0d column rows high", i), kp_if.column, 4'b1111);
            wait_sig($sformatf("table %0d idle", i), 1, 1'b0, 40);
        end

        // Back-to-back pushes against a rotating scanner that holds its row on a hit.
        got_n = 0;
        miss  = 5;
        kp_if.row = 4'b0111;
        @(negedge clk);
        fork
            begin
                push(KEY_1);
                push(KEY_2);
                push(KEY_3);
                push(KEY_A);
                push(KEY_4);
                check1("key_ready low when full", kp_if.key_ready, 1'b0);
            end
            begin
                for (int t = 0; t < 170; t++) begin
                    @(negedge clk);
                    if (kp_if.column != 4'b1111) begin
                        code = decode(kp_if.row, kp_if.column);
                        if (got_n == 0 || (got_n < 8 && code != got[got_n - 1])) begin
                            checki($sformatf("release gap before key %0d", got_n), (miss >= 5) ? 1 : 0, 1);
                            got[got_n] = code;
                            got_n++;
                        end
                        miss = 0;
                    end else begin
                        miss++;
                        kp_if.row = {kp_if.row[0], kp_if.row[3:1]};
                    end
                end
            end
        join
        checki("scanner key count", got_n, 5);
        if (got_n == 5) begin
            check4("scanner key 0", got[0], KEY_1);
            check4("scanner key 1", got[1], KEY_2);
            check4("scanner key 2", got[2], KEY_3);
            check4("scanner key 3", got[3], KEY_A);
            check4("scanner key 4", got[4], KEY_4);
        end
        check1("busy low after sequence", kp_if.busy, 1'b0);
        check1("key_ready after sequence", kp_if.key_ready, 1'b1);

        // Reset during PRESS cycle 7 of key 0 with two keys queued.
        kp_if.row = 4'b0111;
        push(KEY_0);
        push(KEY_5);
        push(KEY_6);
        repeat (7) @(negedge clk);
        check4("column at press cycle 7", kp_if.column, exp_closed(7) ? 4'b1101 : 4'b1111);
        check1("busy before mid-press reset", kp_if.busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check4("async reset column", kp_if.column, 4'b1111);
        check1("async reset pressed", kp_if.pressed, 1'b0);
        check1("async reset busy", kp_if.busy, 1'b0);
        check1("async reset key_ready", kp_if.key_ready, 1'b1);
        check4("async reset key_active", kp_if.key_active, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        hi = 0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (kp_if.pressed || kp_if.busy || kp_if.column != 4'b1111) hi++;
        end
        checki("no queued key pressed after reset", hi, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
